// File: rtl/isa_pkg.sv
// Opcode/funct encodings and register names shared by the issue buffer
// and its instruction classifier.
package isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] F_JR  = 6'h08;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2a;

   localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/issue_classify.sv
// Combinational decode of one instruction into the register/control/memory
// attributes the dual-issue pairing check needs.
module issue_classify
   import isa_pkg::*;
(
   input  logic [31:0] ins,
   output logic [4:0]  dest,
   output logic        has_dest,
   output logic [4:0]  src_a,
   output logic        use_a,
   output logic [4:0]  src_b,
   output logic        use_b,
   output logic        is_ctrl,
   output logic        is_mem,
   output logic        is_unknown
);

   // shamt plays no part in hazard detection
   logic unused_shamt;
   assign unused_shamt = ^ins[10:6];

   always_comb begin
      dest       = '0;
      has_dest   = 1'b0;
      src_a      = ins[25:21];
      src_b      = ins[20:16];
      use_a      = 1'b0;
      use_b      = 1'b0;
      is_ctrl    = 1'b0;
      is_mem     = 1'b0;
      is_unknown = 1'b0;
      case (ins[31:26])
         OP_RTYPE: begin
            use_a = 1'b1;
            if (ins[5:0] == F_JR) begin
               is_ctrl = 1'b1;
            end else begin
               dest     = ins[15:11];
               has_dest = 1'b1;
               use_b    = 1'b1;
            end
         end
         OP_ADDI, OP_LW: begin
            dest     = ins[20:16];
            has_dest = 1'b1;
            use_a    = 1'b1;
            is_mem   = (ins[31:26] == OP_LW);
         end
         OP_SW: begin
            use_a  = 1'b1;
            use_b  = 1'b1;
            is_mem = 1'b1;
         end
         OP_BEQ: begin
            use_a   = 1'b1;
            use_b   = 1'b1;
            is_ctrl = 1'b1;
         end
         OP_JAL: begin
            dest     = REG_RA;
            has_dest = 1'b1;
            is_ctrl  = 1'b1;
         end
         OP_J:    is_ctrl = 1'b1;
         default: is_unknown = 1'b1;
      endcase
   end

endmodule

// File: rtl/issue_buffer.sv
// Circular instruction queue fed by fetch pairs, issuing one or two in-order
// instructions per cycle subject to control/hazard/memory pairing rules.
module issue_buffer
   import isa_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int DW       = 32,
   parameter int PAIR_MEM = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_valid,
   input  logic [DW-1:0]              fetch_ins0,
   input  logic [DW-1:0]              fetch_ins1,
   input  logic [DW-1:0]              fetch_pc,
   output logic                       fetch_ready,
   input  logic                       issue_stall,
   input  logic                       flush,
   output logic [DW-1:0]              ins0,
   output logic [DW-1:0]              ins1,
   output logic [DW-1:0]              pc0,
   output logic [DW-1:0]              pc1,
   output logic                       valid0,
   output logic                       valid1,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem_ins [DEPTH];
   logic [DW-1:0] mem_pc  [DEPTH];
   logic [PW-1:0] rd_ptr, rd_ptr1, wr_ptr;
   logic          push;
   logic [1:0]    n_issue;
   logic [CW-1:0] count_next;
   logic          pair_ok, d0_live, raw_hit, waw_hit;

   logic [4:0] c0_dest, c0_src_a, c0_src_b, c1_dest, c1_src_a, c1_src_b;
   logic       c0_has_dest, c0_use_a, c0_use_b, c0_ctrl, c0_mem, c0_unk;
   logic       c1_has_dest, c1_use_a, c1_use_b, c1_ctrl, c1_mem, c1_unk;

   // Ready depends on registered count only, so a same-cycle pop never frees room.
   assign fetch_ready = (count <= CW'(DEPTH-2));
   assign push        = fetch_valid && fetch_ready && !flush;
   assign rd_ptr1     = rd_ptr + PW'(1);

   issue_classify u_cls0 (
      .ins(mem_ins[rd_ptr][31:0]), .dest(c0_dest), .has_dest(c0_has_dest),
      .src_a(c0_src_a), .use_a(c0_use_a), .src_b(c0_src_b), .use_b(c0_use_b),
      .is_ctrl(c0_ctrl), .is_mem(c0_mem), .is_unknown(c0_unk)
   );

   issue_classify u_cls1 (
      .ins(mem_ins[rd_ptr1][31:0]), .dest(c1_dest), .has_dest(c1_has_dest),
      .src_a(c1_src_a), .use_a(c1_use_a), .src_b(c1_src_b), .use_b(c1_use_b),
      .is_ctrl(c1_ctrl), .is_mem(c1_mem), .is_unknown(c1_unk)
   );

   logic unused_c0_src;
   assign unused_c0_src = ^{c0_src_a, c0_src_b, c0_use_a, c0_use_b};

   assign d0_live = c0_has_dest && (c0_dest != 5'd0);
   assign raw_hit = (c1_use_a && (c1_src_a == c0_dest)) || (c1_use_b && (c1_src_b == c0_dest));
   assign waw_hit = c1_has_dest && (c1_dest == c0_dest);
   assign pair_ok = !c0_ctrl && !c1_ctrl && !c0_unk && !c1_unk
                    && !(d0_live && (raw_hit || waw_hit))
                    && !(c0_mem && c1_mem && (PAIR_MEM == 0));

   always_comb begin
      n_issue = 2'd0;
      if (!issue_stall && !flush && (count != '0))
         n_issue = (pair_ok && (count >= CW'(2))) ? 2'd2 : 2'd1;
      count_next = count + (push ? CW'(2) : CW'(0)) - CW'(n_issue);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_ins[wr_ptr]          <= fetch_ins0;
         mem_pc[wr_ptr]           <= fetch_pc;
         mem_ins[wr_ptr + PW'(1)] <= fetch_ins1;
         mem_pc[wr_ptr + PW'(1)]  <= fetch_pc + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ins0   <= '0;
         ins1   <= '0;
         pc0    <= '0;
         pc1    <= '0;
         valid0 <= 1'b0;
         valid1 <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(2);
         count <= count_next;
         if (!issue_stall) begin
            rd_ptr <= rd_ptr + PW'(n_issue);
            valid0 <= (n_issue != 2'd0);
            ins0   <= (n_issue != 2'd0) ? mem_ins[rd_ptr] : '0;
            pc0    <= (n_issue != 2'd0) ? mem_pc[rd_ptr]  : '0;
            valid1 <= (n_issue == 2'd2);
            ins1   <= (n_issue == 2'd2) ? mem_ins[rd_ptr1] : '0;
            pc1    <= (n_issue == 2'd2) ? mem_pc[rd_ptr1]  : '0;
         end
      end
   end

endmodule

// File: tb/tb_issue_buffer.sv
// Drives two issue_buffer instances (PAIR_MEM 0 and 1) with the same stimulus
// and compares both against a queue-based reference model.
module tb_issue_buffer;
   import isa_pkg::*;

   localparam int DEPTH = 8;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          fetch_valid = 1'b0, issue_stall = 1'b0, flush = 1'b0;
   logic [DW-1:0] fetch_ins0 = '0, fetch_ins1 = '0, fetch_pc = '0;
   logic          fetch_ready [2];
   logic [DW-1:0] ins0 [2], ins1 [2], pc0 [2], pc1 [2];
   logic          valid0 [2], valid1 [2];
   logic [CW-1:0] count [2];

   issue_buffer #(.DEPTH(DEPTH), .DW(DW), .PAIR_MEM(0)) dut0 (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ins0(fetch_ins0),
      .fetch_ins1(fetch_ins1), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready[0]),
      .issue_stall(issue_stall), .flush(flush), .ins0(ins0[0]), .ins1(ins1[0]),
      .pc0(pc0[0]), .pc1(pc1[0]), .valid0(valid0[0]), .valid1(valid1[0]), .count(count[0])
   );

   issue_buffer #(.DEPTH(DEPTH), .DW(DW), .PAIR_MEM(1)) dut1 (
      .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ins0(fetch_ins0),
      .fetch_ins1(fetch_ins1), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready[1]),
      .issue_stall(issue_stall), .flush(flush), .ins0(ins0[1]), .ins1(ins1[1]),
      .pc0(pc0[1]), .pc1(pc1[1]), .valid0(valid0[1]), .valid1(valid1[1]), .count(count[1])
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: a plain FIFO of (instruction, pc) per instance
   typedef struct { logic [31:0] ins; logic [31:0] pc; } ent_t;
   typedef struct { int dest; int src_a; int src_b; bit ctrl; bit mem; bit unk; } cls_t;

   ent_t        q [2][$];
   logic [31:0] e_ins0 [2], e_ins1 [2], e_pc0 [2], e_pc1 [2];
   bit          e_v0 [2], e_v1 [2];

   function automatic cls_t classify(input logic [31:0] i);
      cls_t c;
      int   rs = int'(i[25:21]);
      int   rt = int'(i[20:16]);
      c = '{dest: -1, src_a: -1, src_b: -1, ctrl: 0, mem: 0, unk: 0};
      case (i[31:26])
         OP_RTYPE: if (i[5:0] == F_JR) begin c.ctrl = 1; c.src_a = rs; end
                   else begin c.dest = int'(i[15:11]); c.src_a = rs; c.src_b = rt; end
         OP_ADDI:  begin c.dest = rt; c.src_a = rs; end
         OP_LW:    begin c.dest = rt; c.src_a = rs; c.mem = 1; end
         OP_SW:    begin c.src_a = rs; c.src_b = rt; c.mem = 1; end
         OP_BEQ:   begin c.src_a = rs; c.src_b = rt; c.ctrl = 1; end
         OP_JAL:   begin c.dest = 31; c.ctrl = 1; end
         OP_J:     c.ctrl = 1;
         default:  c.unk = 1;
      endcase
      return c;
   endfunction

   function automatic bit pairable(input cls_t a, input cls_t b, input bit pair_mem);
      if (a.ctrl || b.ctrl || a.unk || b.unk) return 0;
      if (a.dest > 0 && (b.src_a == a.dest || b.src_b == a.dest || b.dest == a.dest)) return 0;
      if (a.mem && b.mem && !pair_mem) return 0;
      return 1;
   endfunction

   task automatic model_edge(input int m, input bit fv, input logic [31:0] i0,
                             input logic [31:0] i1, input logic [31:0] pc,
                             input bit st, input bit fl);
      bit rdy = (q[m].size() <= DEPTH-2);
      if (fl) begin
         q[m].delete();
         e_v0[m] = 0; e_v1[m] = 0; e_ins1[m] = '0;
         return;
      end
      if (!st) begin
         e_v1[m] = 0; e_ins1[m] = '0;
         if (q[m].size() == 0) e_v0[m] = 0;
         else begin
            ent_t a = q[m].pop_front();
            e_v0[m] = 1; e_ins0[m] = a.ins; e_pc0[m] = a.pc;
            if (q[m].size() > 0 && pairable(classify(a.ins), classify(q[m][0].ins), m == 1)) begin
               ent_t b = q[m].pop_front();
               e_v1[m] = 1; e_ins1[m] = b.ins; e_pc1[m] = b.pc;
            end
         end
      end
      if (fv && rdy) begin
         q[m].push_back('{ins: i0, pc: pc});
         q[m].push_back('{ins: i1, pc: pc + 32'd1});
      end
   endtask

   task automatic compare();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("valid0[%0d]", m), 32'(valid0[m]), 32'(e_v0[m]));
         chk($sformatf("valid1[%0d]", m), 32'(valid1[m]), 32'(e_v1[m]));
         chk($sformatf("count[%0d]", m), 32'(count[m]), 32'(q[m].size()));
         if (e_v0[m]) begin
            chk($sformatf("ins0[%0d]", m), ins0[m], e_ins0[m]);
            chk($sformatf("pc0[%0d]", m), pc0[m], e_pc0[m]);
         end
         chk($sformatf("ins1[%0d]", m), ins1[m], e_ins1[m]);
         if (e_v1[m]) chk($sformatf("pc1[%0d]", m), pc1[m], e_pc1[m]);
      end
   endtask

   // called at a negedge; returns at the following negedge with outputs checked
   task automatic step(input bit fv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input bit st, input bit fl);
      for (int m = 0; m < 2; m++)
         chk($sformatf("fetch_ready[%0d]", m), 32'(fetch_ready[m]), 32'(q[m].size() <= DEPTH-2));
      fetch_valid = fv; fetch_ins0 = i0; fetch_ins1 = i1; fetch_pc = pc;
      issue_stall = st; flush = fl;
      for (int m = 0; m < 2; m++) model_edge(m, fv, i0, i1, pc, st, fl);
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic idle();
      step(0, '0, '0, '0, 0, 0);
   endtask

   function automatic logic [31:0] rnd_ins();
      logic [4:0] rs = 5'($urandom_range(0, 3));
      logic [4:0] rt = 5'($urandom_range(0, 3));
      logic [4:0] rd = 5'($urandom_range(0, 3));
      logic [5:0] fns [5] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      case ($urandom_range(0, 11))
         0, 1, 2, 3: return {OP_RTYPE, rs, rt, rd, 5'd0, fns[$urandom_range(0, 4)]};
         4:          return {OP_ADDI, rs, rt, 16'h0010};
         5, 6:       return {OP_LW, rs, rt, 16'h0004};
         7:          return {OP_SW, rs, rt, 16'h0008};
         8:          return {OP_BEQ, rs, rt, 16'h0002};
         9:          return {OP_RTYPE, rs, 15'd0, F_JR};
         10:         return ($urandom_range(0, 1) != 0) ? {OP_J, 26'h40} : {OP_JAL, 26'h40};
         default:    return {6'h3f, rs, rt, 16'h0000};
      endcase
   endfunction

   task automatic rnd_step(input logic [31:0] pc);
      step($urandom_range(0, 3) != 0, rnd_ins(), rnd_ins(), pc,
           $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0);
   endtask

   initial begin
      logic [31:0] pcr;
      for (int m = 0; m < 2; m++) begin
         e_v0[m] = 0; e_v1[m] = 0;
         e_ins0[m] = '0; e_ins1[m] = '0; e_pc0[m] = '0; e_pc1[m] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         chk("rst_valid0", 32'(valid0[m]), 32'd0);
         chk("rst_valid1", 32'(valid1[m]), 32'd0);
         chk("rst_count", 32'(count[m]), 32'd0);
         chk("rst_ins0", ins0[m], 32'd0);
         chk("rst_ready", 32'(fetch_ready[m]), 32'd1);
      end
      rst = 1'b1;

      // RAW-dependent pair issues one per cycle
      step(1, 32'h01095020, 32'h01495820, 32'd0, 0, 0);
      idle();
      chk("raw_ins0", ins0[0], 32'h01095020);
      chk("raw_valid1", 32'(valid1[0]), 32'd0);
      idle();
      chk("raw_ins0_b", ins0[0], 32'h01495820);
      chk("raw_pc0_b", pc0[0], 32'd1);

      // independent pair issues together
      step(1, 32'h01095020, 32'h01095820, 32'd0, 0, 0);
      idle();
      chk("indep_valid1", 32'(valid1[0]), 32'd1);
      chk("indep_pc1", pc1[0], 32'd1);
      chk("indep_count", 32'(count[0]), 32'd0);

      // beq + add, then add + jal
      step(1, 32'h10220004, 32'h01095020, 32'h10, 0, 0);
      step(1, 32'h01095020, 32'h0c000040, 32'h20, 0, 0);
      repeat (4) idle();

      // fill under stall from an odd count, then drain across the wrap
      step(1, 32'h01095020, 32'h01495820, 32'h30, 0, 0);
      idle();
      for (int i = 0; i < 5; i++) step(1, rnd_ins(), rnd_ins(), 32'h40 + 32'(2*i), 1, 0);
      chk("full_count", 32'(count[0]), 32'd7);
      chk("full_ready", 32'(fetch_ready[0]), 32'd0);
      repeat (8) idle();

      // flush at count 4 with a simultaneous push
      step(1, rnd_ins(), rnd_ins(), 32'h80, 1, 0);
      step(1, rnd_ins(), rnd_ins(), 32'h82, 1, 0);
      chk("pre_flush_count", 32'(count[0]), 32'd4);
      step(1, 32'h01095020, 32'h01095820, 32'h90, 0, 1);
      chk("flush_count", 32'(count[0]), 32'd0);
      chk("flush_ready", 32'(fetch_ready[0]), 32'd1);
      idle();
      chk("flush_dropped", 32'(valid0[0]), 32'd0);

      // two loads: split without PAIR_MEM, paired with it
      step(1, 32'h8c080000, 32'h8c090004, 32'ha0, 0, 0);
      idle();
      chk("lw_split", 32'(valid1[0]), 32'd0);
      chk("lw_pair", 32'(valid1[1]), 32'd1);
      repeat (2) idle();

      pcr = 32'h100;
      repeat (3000) begin
         rnd_step(pcr);
         pcr += 32'd2;
      end

      // async reset mid-stream, between clock edges
      step(1, 32'h01095020, 32'h01095820, pcr, 0, 0);
      step(1, 32'h01095020, 32'h01095820, pcr + 32'd2, 0, 0);
      #1 rst = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("arst_valid0", 32'(valid0[m]), 32'd0);
         chk("arst_valid1", 32'(valid1[m]), 32'd0);
         chk("arst_count", 32'(count[m]), 32'd0);
         chk("arst_ins0", ins0[m], 32'd0);
         q[m].delete();
         e_v0[m] = 0; e_v1[m] = 0; e_ins1[m] = '0;
      end
      fetch_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (300) begin
         rnd_step(pcr);
         pcr += 32'd2;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
